// File: rtl/hci_tcdm_bank_monitor.sv
// Passive TCDM bank monitor: rebuilds granted accesses into records, queues them for a scoreboard
// and keeps throughput counters. Optional stall statistics are enabled by macro HCI_BANK_MON_STALL_EN.
module hci_tcdm_bank_monitor #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_MEM_WIDTH = 11,
    parameter int unsigned N_BANKS        = 16,
    parameter int unsigned BANK_ID        = 0,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned CNT_WIDTH      = 16,
    localparam int unsigned BIT_BANK_INDEX = $clog2(N_BANKS),
    localparam int unsigned ADD_WIDTH      = ADDR_MEM_WIDTH + BIT_BANK_INDEX,
    localparam int unsigned LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  mem_req_i,
    input  logic                  mem_gnt_i,
    input  logic                  mem_wen_i,
    input  logic [ADDR_MEM_WIDTH-1:0] mem_add_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [DATA_WIDTH-1:0] mem_r_data_i,
    output logic                  rec_valid_o,
    input  logic                  rec_ready_i,
    output logic                  rec_wen_o,
    output logic [ADD_WIDTH-1:0]  rec_add_o,
    output logic [DATA_WIDTH-1:0] rec_data_o,
    output logic [LVL_W-1:0]      fifo_level_o,
    output logic [CNT_WIDTH-1:0]  n_reads_o,
    output logic [CNT_WIDTH-1:0]  n_writes_o,
    output logic                  overflow_o,
    output logic [CNT_WIDTH-1:0]  stall_cycles_o,
    output logic [CNT_WIDTH-1:0]  max_stall_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [BIT_BANK_INDEX-1:0] BANK_BITS = BIT_BANK_INDEX'(BANK_ID);
    localparam logic [LVL_W-1:0]     LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic                  wen;
        logic [ADD_WIDTH-1:0]  add;
        logic [DATA_WIDTH-1:0] data;
    } rec_t;

    logic                  access;
    logic [ADD_WIDTH-1:0]  rebuilt_add;

    logic                  stg_valid_q;
    logic                  stg_wen_q;
    logic [ADD_WIDTH-1:0]  stg_add_q;
    logic [DATA_WIDTH-1:0] stg_data_q;

    rec_t                  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  overflow_q;
    logic [CNT_WIDTH-1:0]  n_reads_q, n_writes_q;

    rec_t                  push_rec;
    rec_t                  head;
    logic                  push, pop, push_ok, drop, empty, full;

    assign access      = mem_req_i & mem_gnt_i;
    assign rebuilt_add = {mem_add_i[ADDR_MEM_WIDTH-1:2], BANK_BITS, mem_add_i[1:0]};

    // Stage holds the granted request; read data only arrives one cycle later.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            stg_valid_q <= 1'b0;
            stg_wen_q   <= 1'b0;
            stg_add_q   <= '0;
            stg_data_q  <= '0;
        end else begin
            stg_valid_q <= access;
            if (access) begin
                stg_wen_q  <= mem_wen_i;
                stg_add_q  <= rebuilt_add;
                stg_data_q <= mem_data_i;
            end
        end
    end

    always_comb begin
        push_rec      = '0;
        push_rec.wen  = stg_wen_q;
        push_rec.add  = stg_add_q;
        push_rec.data = stg_wen_q ? mem_r_data_i : stg_data_q;
    end

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_FULL);
    assign push    = stg_valid_q;
    assign pop     = rec_ready_i & ~empty;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_rec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            n_reads_q  <= '0;
            n_writes_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push_ok) level_q <= level_q - 1'b1;
            if (drop) overflow_q <= 1'b1;
            // Counters track attempts, so dropped records are still counted.
            if (push && stg_wen_q && (n_reads_q != CNT_MAX))   n_reads_q  <= n_reads_q + 1'b1;
            if (push && !stg_wen_q && (n_writes_q != CNT_MAX)) n_writes_q <= n_writes_q + 1'b1;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign rec_valid_o  = ~empty;
    assign rec_wen_o    = ~empty & head.wen;
    assign rec_add_o    = empty ? '0 : head.add;
    assign rec_data_o   = empty ? '0 : head.data;
    assign fifo_level_o = level_q;
    assign n_reads_o    = n_reads_q;
    assign n_writes_o   = n_writes_q;
    assign overflow_o   = overflow_q;

`ifdef HCI_BANK_MON_STALL_EN
    logic                 stalled;
    logic [CNT_WIDTH-1:0] run_q, stall_q, max_q, run_inc;

    assign stalled = mem_req_i & ~mem_gnt_i;
    assign run_inc = (run_q == CNT_MAX) ? run_q : run_q + 1'b1;

    // The maximum follows the running count, so it is current both mid-run and after it ends.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            run_q   <= '0;
            stall_q <= '0;
            max_q   <= '0;
        end else if (stalled) begin
            run_q <= run_inc;
            if (stall_q != CNT_MAX) stall_q <= stall_q + 1'b1;
            if (run_inc > max_q)    max_q   <= run_inc;
        end else begin
            run_q <= '0;
        end
    end

    assign stall_cycles_o = stall_q;
    assign max_stall_o    = max_q;
`else
    assign stall_cycles_o = '0;
    assign max_stall_o    = '0;
`endif

endmodule

// File: tb/tb_hci_tcdm_bank_monitor.sv
// Directed bench for hci_tcdm_bank_monitor with BANK_ID=3: vector table plus FIFO/clear/stall sequences.
module tb_hci_tcdm_bank_monitor;

    localparam int DW = 32;
    localparam int AMW = 11;
    localparam int AW = 15;
    localparam int LW = 4;
    localparam int CW = 16;

    logic          clk, rst_ni, clear, req, gnt, wen, rdy;
    logic [AMW-1:0] add;
    logic [DW-1:0] wdata, rdata;
    logic          rec_valid, rec_wen, overflow;
    logic [AW-1:0] rec_add;
    logic [DW-1:0] rec_data;
    logic [LW-1:0] level;
    logic [CW-1:0] n_reads, n_writes, stall_cycles, max_stall;

    int checks = 0;
    int failures = 0;

    hci_tcdm_bank_monitor #(
        .DATA_WIDTH(DW), .ADDR_MEM_WIDTH(AMW), .N_BANKS(16), .BANK_ID(3),
        .FIFO_DEPTH(8), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear),
        .mem_req_i(req), .mem_gnt_i(gnt), .mem_wen_i(wen), .mem_add_i(add),
        .mem_data_i(wdata), .mem_r_data_i(rdata),
        .rec_valid_o(rec_valid), .rec_ready_i(rdy), .rec_wen_o(rec_wen),
        .rec_add_o(rec_add), .rec_data_o(rec_data), .fifo_level_o(level),
        .n_reads_o(n_reads), .n_writes_o(n_writes), .overflow_o(overflow),
        .stall_cycles_o(stall_cycles), .max_stall_o(max_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          req, gnt, wen;
        logic [AMW-1:0] add;
        logic [DW-1:0] wdata, rdata;
        logic          rdy;
        logic          e_valid, e_wen;
        logic [AW-1:0] e_add;
        logic [DW-1:0] e_data;
        logic [LW-1:0] e_level;
        logic [CW-1:0] e_nr, e_nw;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic r, logic g, logic w, logic [AMW-1:0] a, logic [DW-1:0] wd,
                                logic [DW-1:0] rd, logic rr, logic ev, logic ew, logic [AW-1:0] ea,
                                logic [DW-1:0] ed, logic [LW-1:0] el, logic [CW-1:0] nr, logic [CW-1:0] nw);
        vec_t v;
        v.req = r; v.gnt = g; v.wen = w; v.add = a; v.wdata = wd; v.rdata = rd; v.rdy = rr;
        v.e_valid = ev; v.e_wen = ew; v.e_add = ea; v.e_data = ed; v.e_level = el;
        v.e_nr = nr; v.e_nw = nw;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic g, input logic w, input logic [AMW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic rr,
                          input logic cl);
        req = r; gnt = g; wen = w; add = a; wdata = wd; rdata = rd; rdy = rr; clear = cl;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] bank_add(input int a);
        return AW'(((a >> 2) << 6) | (3 << 2) | (a & 3));
    endfunction

    logic [CW-1:0] exp_stall_total, exp_stall_max, exp_stall_mid;

    initial begin
        rst_ni = 1'b0;
        set_in(1, 1, 0, 11'h123, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        tick(); tick();
        chk("reset.valid", rec_valid, 0);
        chk("reset.level", level, 0);
        chk("reset.rec_add", rec_add, 0);
        chk("reset.rec_data", rec_data, 0);
        chk("reset.counters", {n_reads, n_writes}, 0);
        chk("reset.overflow", overflow, 0);
        chk("reset.stall", {stall_cycles, max_stall}, 0);
        rst_ni = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post_reset.level", level, 0);

        //          req gnt wen add     wdata          rdata          rdy  v  w  add       data           lvl nr nw
        vecs[0]  = mk(1, 1, 0, 11'h005, 32'hCAFE_0001, 32'h0,         0,   0, 0, 15'h0,    32'h0,         0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 11'h000, 32'h0,         32'h0,         0,   1, 0, 15'h04D,  32'hCAFE_0001, 1, 0, 1);
        vecs[2]  = mk(1, 1, 1, 11'h010, 32'h0BAD_0BAD, 32'h0,         1,   0, 0, 15'h0,    32'h0,         0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 11'h000, 32'h0,         32'h1234_5678, 0,   1, 1, 15'h10C,  32'h1234_5678, 1, 1, 1);
        vecs[4]  = mk(1, 0, 0, 11'h7FF, 32'h0,         32'h0,         0,   1, 1, 15'h10C,  32'h1234_5678, 1, 1, 1);
        vecs[5]  = mk(0, 0, 0, 11'h000, 32'h0,         32'h0,         1,   0, 0, 15'h0,    32'h0,         0, 1, 1);
        vecs[6]  = mk(0, 0, 0, 11'h000, 32'h0,         32'h0,         1,   0, 0, 15'h0,    32'h0,         0, 1, 1);
        vecs[7]  = mk(1, 1, 0, 11'h7FF, 32'hA5A5_A5A5, 32'h0,         0,   0, 0, 15'h0,    32'h0,         0, 1, 1);
        vecs[8]  = mk(0, 0, 0, 11'h000, 32'h0,         32'hDEAD_BEEF, 0,   1, 0, 15'h7FCF, 32'hA5A5_A5A5, 1, 1, 2);
        vecs[9]  = mk(1, 1, 0, 11'h001, 32'h1111_1111, 32'h0,         0,   1, 0, 15'h7FCF, 32'hA5A5_A5A5, 1, 1, 2);
        vecs[10] = mk(1, 1, 1, 11'h002, 32'h0,         32'h9999_9999, 0,   1, 0, 15'h7FCF, 32'hA5A5_A5A5, 2, 1, 3);
        vecs[11] = mk(0, 0, 0, 11'h000, 32'h0,         32'h2222_2222, 1,   1, 0, 15'h00D,  32'h1111_1111, 2, 2, 3);
        vecs[12] = mk(0, 0, 0, 11'h000, 32'h0,         32'h0,         1,   1, 1, 15'h00E,  32'h2222_2222, 1, 2, 3);
        vecs[13] = mk(0, 0, 0, 11'h000, 32'h0,         32'h0,         1,   0, 0, 15'h0,    32'h0,         0, 2, 3);

        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].req, vecs[i].gnt, vecs[i].wen, vecs[i].add, vecs[i].wdata,
                   vecs[i].rdata, vecs[i].rdy, 0);
            tick();
            chk($sformatf("vec%0d.valid", i), rec_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d.wen", i), rec_wen, vecs[i].e_wen);
            chk($sformatf("vec%0d.add", i), rec_add, vecs[i].e_add);
            chk($sformatf("vec%0d.data", i), rec_data, vecs[i].e_data);
            chk($sformatf("vec%0d.level", i), level, vecs[i].e_level);
            chk($sformatf("vec%0d.n_reads", i), n_reads, vecs[i].e_nr);
            chk($sformatf("vec%0d.n_writes", i), n_writes, vecs[i].e_nw);
            chk($sformatf("vec%0d.overflow", i), overflow, 0);
        end

        // Full FIFO with simultaneous push and pop.
        set_in(0, 0, 0, 0, 0, 0, 0, 1); tick();
        for (int i = 1; i <= 8; i++) begin
            set_in(1, 1, 0, AMW'(i), DW'(i), 0, 0, 0); tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("full.level", level, 8);
        chk("full.overflow", overflow, 0);
        set_in(1, 1, 0, 11'h020, 32'h100, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 0); tick();
        chk("pushpop.level", level, 8);
        chk("pushpop.overflow", overflow, 0);
        chk("pushpop.n_writes", n_writes, 9);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("pushpop.pop%0d.data", k), rec_data, (k < 7) ? 32'(k + 2) : 32'h100);
            chk($sformatf("pushpop.pop%0d.add", k), rec_add, (k < 7) ? bank_add(k + 2) : 15'h20C);
            tick();
        end
        chk("pushpop.drained", level, 0);

        // Overflow: nine pushes into eight entries.
        set_in(0, 0, 0, 0, 0, 0, 0, 1); tick();
        for (int i = 1; i <= 9; i++) begin
            set_in(1, 1, 0, AMW'(i), DW'(i), 0, 0, 0); tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("ovf.level", level, 8);
        chk("ovf.overflow", overflow, 1);
        chk("ovf.n_writes", n_writes, 9);
        chk("ovf.n_reads", n_reads, 0);
        rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf.pop%0d.data", i), rec_data, 32'(i));
            chk($sformatf("ovf.pop%0d.wen", i), rec_wen, 0);
            chk($sformatf("ovf.pop%0d.add", i), rec_add, bank_add(i));
            tick();
        end
        chk("ovf.drained", level, 0);
        chk("ovf.sticky", overflow, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 1); tick();
        chk("ovf.cleared", overflow, 0);

        // Clear in the same cycle as a grant, with three records queued.
        for (int i = 1; i <= 3; i++) begin
            set_in(1, 1, 0, AMW'(i), DW'(i), 0, 0, 0); tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("clr.queued", level, 3);
        set_in(1, 1, 0, 11'h044, 32'h0000_BEEF, 0, 0, 1); tick();
        chk("clr.level", level, 0);
        chk("clr.counters", {n_reads, n_writes}, 0);
        chk("clr.valid", rec_valid, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("clr.after%0d.valid", i), rec_valid, 0);
            chk($sformatf("clr.after%0d.n_writes", i), n_writes, 0);
        end

        // Stall statistics: a 4-cycle run, then a 2-cycle run.
`ifdef HCI_BANK_MON_STALL_EN
        exp_stall_mid = 4; exp_stall_total = 6; exp_stall_max = 4;
`else
        exp_stall_mid = 0; exp_stall_total = 0; exp_stall_max = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 1, 11'h008, 0, 0, 0, 0); tick();
        end
        chk("stall.mid.cycles", stall_cycles, exp_stall_mid);
        chk("stall.mid.max", max_stall, exp_stall_mid);
        set_in(1, 1, 1, 11'h008, 0, 0, 0, 0); tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 1, 11'h009, 0, 0, 0, 0); tick();
        end
        set_in(1, 1, 1, 11'h009, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("stall.cycles", stall_cycles, exp_stall_total);
        chk("stall.max", max_stall, exp_stall_max);
        chk("stall.n_reads", n_reads, 2);
        chk("stall.level", level, 2);

        // Reset mid-run clears everything.
        rst_ni = 1'b0; tick();
        rst_ni = 1'b1;
        chk("rst2.level", level, 0);
        chk("rst2.valid", rec_valid, 0);
        chk("rst2.n_reads", n_reads, 0);
        chk("rst2.stall", {stall_cycles, max_stall}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
